// File: rtl/ascii_ps2_tx.sv
// ASCII character to PS/2 set-2 keystroke (make, F0, make) serialiser.
// Each byte goes out as an 11-bit device-to-host frame on ps2_clk/ps2_data.
module ascii_ps2_tx #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ascii_valid,
   input  logic [7:0] ascii,
   output logic       ascii_ready,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       busy,
   output logic       err
);

   typedef enum logic [2:0] {IDLE, DECODE, BIT_HI, BIT_LO, GAP} state_t;

   localparam int DW = $clog2(2 * CLK_DIV);
   localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] GAP_LAST  = DW'(2 * CLK_DIV - 1);

   // Returns {hit, make_code}; upper-case letters fold onto lower case.
   function automatic logic [8:0] lookup(input logic [7:0] c);
      logic [7:0] k;
      logic [8:0] r;
      k = (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
      case (k)
         8'h61: r = {1'b1, 8'h1C};  8'h62: r = {1'b1, 8'h32};
         8'h63: r = {1'b1, 8'h21};  8'h64: r = {1'b1, 8'h23};
         8'h65: r = {1'b1, 8'h24};  8'h66: r = {1'b1, 8'h2B};
         8'h67: r = {1'b1, 8'h34};  8'h68: r = {1'b1, 8'h33};
         8'h69: r = {1'b1, 8'h43};  8'h6A: r = {1'b1, 8'h3B};
         8'h6B: r = {1'b1, 8'h42};  8'h6C: r = {1'b1, 8'h4B};
         8'h6D: r = {1'b1, 8'h3A};  8'h6E: r = {1'b1, 8'h31};
         8'h6F: r = {1'b1, 8'h44};  8'h70: r = {1'b1, 8'h4D};
         8'h71: r = {1'b1, 8'h15};  8'h72: r = {1'b1, 8'h2D};
         8'h73: r = {1'b1, 8'h1B};  8'h74: r = {1'b1, 8'h2C};
         8'h75: r = {1'b1, 8'h3C};  8'h76: r = {1'b1, 8'h2A};
         8'h77: r = {1'b1, 8'h1D};  8'h78: r = {1'b1, 8'h22};
         8'h79: r = {1'b1, 8'h35};  8'h7A: r = {1'b1, 8'h1A};
         8'h30: r = {1'b1, 8'h45};  8'h31: r = {1'b1, 8'h16};
         8'h32: r = {1'b1, 8'h1E};  8'h33: r = {1'b1, 8'h26};
         8'h34: r = {1'b1, 8'h25};  8'h35: r = {1'b1, 8'h2E};
         8'h36: r = {1'b1, 8'h36};  8'h37: r = {1'b1, 8'h3D};
         8'h38: r = {1'b1, 8'h3E};  8'h39: r = {1'b1, 8'h46};
         8'h20: r = {1'b1, 8'h29};  8'h0D: r = {1'b1, 8'h5A};
         8'h08: r = {1'b1, 8'h66};
         default: r = 9'h000;
      endcase
      return r;
   endfunction

   // Frame bit idx: 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
   function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
      logic [3:0] j;
      logic       r;
      j = idx - 4'd1;
      if (idx == 4'd0)      r = 1'b0;
      else if (idx <= 4'd8) r = b[j[2:0]];
      else if (idx == 4'd9) r = ~^b;
      else                  r = 1'b1;
      return r;
   endfunction

   state_t          state, state_n;
   logic [DW-1:0]   div_cnt, div_n;
   logic [3:0]      bit_idx, bit_n;
   logic [1:0]      byte_idx, byte_n;
   logic [7:0]      code, code_n;
   logic [8:0]      hit_code;
   logic [7:0]      tx_byte;
   logic            busy_n, err_n, ready_n, clk_n, data_n;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_n  = state;
      div_n    = div_cnt;
      bit_n    = bit_idx;
      byte_n   = byte_idx;
      code_n   = code;
      busy_n   = busy;
      err_n    = 1'b0;
      hit_code = lookup(ascii);

      case (state)
         IDLE: begin
            if (ascii_valid) begin
               state_n = DECODE;
               if (hit_code[8]) begin
                  code_n = hit_code[7:0];
                  busy_n = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         // busy already tells whether the latched character had a mapping
         DECODE: begin
            div_n   = '0;
            bit_n   = 4'd0;
            byte_n  = 2'd0;
            state_n = busy ? BIT_HI : IDLE;
         end
         BIT_HI: begin
            if (div_cnt == HALF_LAST) begin
               div_n   = '0;
               state_n = BIT_LO;
            end else begin
               div_n = div_cnt + 1'b1;
            end
         end
         BIT_LO: begin
            if (div_cnt == HALF_LAST) begin
               div_n = '0;
               if (bit_idx == 4'd10) begin
                  state_n = GAP;
               end else begin
                  bit_n   = bit_idx + 4'd1;
                  state_n = BIT_HI;
               end
            end else begin
               div_n = div_cnt + 1'b1;
            end
         end
         GAP: begin
            if (div_cnt == GAP_LAST) begin
               div_n = '0;
               bit_n = 4'd0;
               if (byte_idx == 2'd2) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
               end else begin
                  byte_n  = byte_idx + 2'd1;
                  state_n = BIT_HI;
               end
            end else begin
               div_n = div_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      tx_byte = (byte_n == 2'd1) ? 8'hF0 : code_n;
      ready_n = (state_n == IDLE);
      clk_n   = (state_n != BIT_LO);
      data_n  = (state_n == BIT_HI || state_n == BIT_LO) ? frame_bit(tx_byte, bit_n) : 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!clrn) begin
         state       <= IDLE;
         div_cnt     <= '0;
         bit_idx     <= 4'd0;
         byte_idx    <= 2'd0;
         code        <= 8'h00;
         busy        <= 1'b0;
         err         <= 1'b0;
         ascii_ready <= 1'b1;
         ps2_clk     <= 1'b1;
         ps2_data    <= 1'b1;
      end else begin
         state       <= state_n;
         div_cnt     <= div_n;
         bit_idx     <= bit_n;
         byte_idx    <= byte_n;
         code        <= code_n;
         busy        <= busy_n;
         err         <= err_n;
         ascii_ready <= ready_n;
         ps2_clk     <= clk_n;
         ps2_data    <= data_n;
      end
   end

endmodule

// File: tb/tb_ascii_ps2_tx.sv
// Bench for ascii_ps2_tx: character table driven through the DUT, a PS/2
// receiver model checks frames against a queue of expected bytes.
module tb_ascii_ps2_tx;

   localparam int CLK_DIV    = 4;
   localparam int KEY_CYCLES = 1 + 72 * CLK_DIV;

   typedef struct {
      logic [7:0] ch;
      logic       mapped;
      logic [7:0] code;
   } vec_t;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ascii_valid = 1'b0;
   logic [7:0] ascii = 8'h00;
   logic       ascii_ready, ps2_clk, ps2_data, busy, err;

   ascii_ps2_tx #(.CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .clrn(clrn), .ascii_valid(ascii_valid), .ascii(ascii),
      .ascii_ready(ascii_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   int         falls = 0;
   int         frames = 0;
   int         exp_frames = 0;
   int         stable_viol = 0;
   vec_t       vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Receiver model: samples on ps2_clk falling edges, checks framing, pops expected bytes.
   initial begin
      logic [10:0] frame;
      int          nbits;
      logic        prev_clk, prev_data;
      frame = '0;
      nbits = 0;
      prev_clk = 1'b1;
      prev_data = 1'b1;
      forever begin
         @(negedge clk);
         if (!clrn) begin
            nbits = 0;
            exp_q.delete();
         end else begin
            if (!prev_clk && !ps2_clk && ps2_data !== prev_data) stable_viol++;
            if (prev_clk && !ps2_clk) begin
               falls++;
               frame[nbits] = ps2_data;
               nbits++;
               if (nbits == 11) begin
                  nbits = 0;
                  frames++;
                  check("frame_start", 32'(frame[0]), 32'd0);
                  check("frame_stop", 32'(frame[10]), 32'd1);
                  check("frame_odd_parity", 32'(^frame[9:1]), 32'd1);
                  if (exp_q.size() == 0) begin
                     n_cmp++;
                     n_fail++;
                     $display("FAIL sb_byte: got %0h, want nothing pending", frame[8:1]);
                  end else begin
                     check("sb_byte", 32'(frame[8:1]), 32'(exp_q.pop_front()));
                  end
               end
            end
         end
         prev_clk = ps2_clk;
         prev_data = ps2_data;
      end
   end

   task automatic add(input logic [7:0] ch, input logic mapped, input logic [7:0] code);
      vec_t v;
      v.ch = ch;
      v.mapped = mapped;
      v.code = code;
      vecs.push_back(v);
   endtask

   task automatic push_key(input logic [7:0] code);
      exp_q.push_back(code);
      exp_q.push_back(8'hF0);
      exp_q.push_back(code);
      exp_frames += 3;
   endtask

   // Returns posedges counted until ascii_ready is seen high (bounded).
   task automatic wait_ready(output int n);
      n = 0;
      while (!ascii_ready && n < KEY_CYCLES + 50) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!ascii_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("idle_before_send", 32'(ascii_ready), 32'd1);
   endtask

   task automatic send_key(input logic [7:0] ch, input logic mapped, input logic [7:0] code);
      int n;
      int f0;
      wait_idle();
      if (mapped) push_key(code);
      f0 = falls;
      ascii = ch;
      ascii_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ascii_valid = 1'b0;
      check($sformatf("accept_ready[%h]", ch), 32'(ascii_ready), 32'd0);
      check($sformatf("accept_err[%h]", ch), 32'(err), 32'(!mapped));
      check($sformatf("accept_busy[%h]", ch), 32'(busy), 32'(mapped));
      if (mapped) begin
         wait_ready(n);
         check($sformatf("ready_cycles[%h]", ch), 32'(n), 32'(KEY_CYCLES));
         check($sformatf("busy_done[%h]", ch), 32'(busy), 32'd0);
         check($sformatf("clk_falls[%h]", ch), 32'(falls - f0), 32'd33);
      end else begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("err_one_cycle[%h]", ch), 32'(err), 32'd0);
         check($sformatf("unmapped_busy[%h]", ch), 32'(busy), 32'd0);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("unmapped_ready[%h]", ch), 32'(ascii_ready), 32'd1);
         check($sformatf("unmapped_lines[%h]", ch), 32'({ps2_clk, ps2_data}), 32'd3);
         check($sformatf("unmapped_falls[%h]", ch), 32'(falls - f0), 32'd0);
      end
   endtask

   initial begin
      int n;
      int run;
      int max_low;
      logic [7:0] up;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(ascii_ready), 32'd1);
      check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
      check("rst_ps2_data", 32'(ps2_data), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      clrn = 1'b1;

      // Character table
      add(8'h61, 1, 8'h1C); add(8'h62, 1, 8'h32); add(8'h63, 1, 8'h21); add(8'h64, 1, 8'h23);
      add(8'h65, 1, 8'h24); add(8'h66, 1, 8'h2B); add(8'h67, 1, 8'h34); add(8'h68, 1, 8'h33);
      add(8'h69, 1, 8'h43); add(8'h6A, 1, 8'h3B); add(8'h6B, 1, 8'h42); add(8'h6C, 1, 8'h4B);
      add(8'h6D, 1, 8'h3A); add(8'h6E, 1, 8'h31); add(8'h6F, 1, 8'h44); add(8'h70, 1, 8'h4D);
      add(8'h71, 1, 8'h15); add(8'h72, 1, 8'h2D); add(8'h73, 1, 8'h1B); add(8'h74, 1, 8'h2C);
      add(8'h75, 1, 8'h3C); add(8'h76, 1, 8'h2A); add(8'h77, 1, 8'h1D); add(8'h78, 1, 8'h22);
      add(8'h79, 1, 8'h35); add(8'h7A, 1, 8'h1A);
      add(8'h30, 1, 8'h45); add(8'h31, 1, 8'h16); add(8'h32, 1, 8'h1E); add(8'h33, 1, 8'h26);
      add(8'h34, 1, 8'h25); add(8'h35, 1, 8'h2E); add(8'h36, 1, 8'h36); add(8'h37, 1, 8'h3D);
      add(8'h38, 1, 8'h3E); add(8'h39, 1, 8'h46);
      add(8'h20, 1, 8'h29); add(8'h0D, 1, 8'h5A); add(8'h08, 1, 8'h66);
      for (int i = 0; i < 26; i++) begin
         up = vecs[i].ch - 8'h20;
         add(up, 1, vecs[i].code);
      end
      add(8'h7E, 0, 8'h00); add(8'h40, 0, 8'h00); add(8'h5B, 0, 8'h00);
      add(8'h7B, 0, 8'h00); add(8'h00, 0, 8'h00); add(8'hFF, 0, 8'h00);

      for (int i = 0; i < vecs.size(); i++) send_key(vecs[i].ch, vecs[i].mapped, vecs[i].code);

      // 'A' then '7' with ascii_valid held throughout
      wait_idle();
      push_key(8'h1C);
      push_key(8'h3D);
      ascii = 8'h41;
      ascii_valid = 1'b1;
      n = 0;
      while (ascii_ready && n < 5) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      check("held_first_accept", 32'(ascii_ready), 32'd0);
      ascii = 8'h37;
      n = 0;
      run = 0;
      max_low = 0;
      while (!ascii_ready && n < KEY_CYCLES + 50) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         run = busy ? 0 : run + 1;
         if (run > max_low) max_low = run;
      end
      check("held_first_cycles", 32'(n), 32'(KEY_CYCLES));
      @(posedge clk);
      @(negedge clk);
      ascii_valid = 1'b0;
      run = busy ? 0 : run + 1;
      if (run > max_low) max_low = run;
      check("held_second_accept", 32'({ascii_ready, busy}), 32'b01);
      check("held_busy_gap_le1", 32'(max_low <= 1), 32'd1);
      wait_ready(n);
      check("held_second_cycles", 32'(n), 32'(KEY_CYCLES));

      // Reset during bit 5 of the F0 frame, then a clean 'z'
      wait_idle();
      push_key(8'h1C);
      exp_frames -= 2;
      ascii = 8'h61;
      ascii_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ascii_valid = 1'b0;
      repeat (139) @(posedge clk);
      @(negedge clk);
      clrn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_lines", 32'({ps2_clk, ps2_data}), 32'd3);
      check("midrst_ready_busy_err", 32'({ascii_ready, busy, err}), 32'b100);
      @(posedge clk);
      @(negedge clk);
      clrn = 1'b1;
      check("midrst_sb_flushed", 32'(exp_q.size()), 32'd0);
      send_key(8'h7A, 1, 8'h1A);

      repeat (4) @(negedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      check("frames_seen", 32'(frames), 32'(exp_frames));
      check("data_stable_while_clk_low", 32'(stable_viol), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
